mem_read_dma: RTL and testbench

- AXI3 read-DMA engine; sits between the register block (go / source address / length) and the miner datapath.
- On a go pulse it fetches Length bytes from DRAM starting at the source pointer, using INCR bursts on the memory read channels.
- Delivers the data in order as a valid/ready 64-bit word stream with a last marker.
- Drives only the AR/R channels of the memory master port; AW/W/B stay tied off at top level.

---
 rtl/mem_read_dma_if.sv | 39 +++
 rtl/mem_read_dma.sv | 172 +++++++++++++++++
 tb/tb_mem_read_dma.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_read_dma_if.sv
// AXI3 read-address and read-data channels between the read-DMA master and
// the memory slave. Write channels are not carried here.
interface mem_read_dma_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int LEN_WIDTH  = 4,
  parameter int ID_WIDTH   = 6
);
  logic                  arvalid;
  logic                  arready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [LEN_WIDTH-1:0]  arlen;
  logic [ID_WIDTH-1:0]   arid;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic [1:0]            arlock;
  logic [3:0]            arcache;
  logic [2:0]            arprot;
  logic [3:0]            arqos;

  logic                  rvalid;
  logic                  rready;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rlast;
  logic [1:0]            rresp;
  logic [ID_WIDTH-1:0]   rid;

  modport master (
    output arvalid, araddr, arlen, arid, arsize, arburst, arlock, arcache,
           arprot, arqos, rready,
    input  arready, rvalid, rdata, rlast, rresp, rid
  );

  modport slave (
    input  arvalid, araddr, arlen, arid, arsize, arburst, arlock, arcache,
           arprot, arqos, rready,
    output arready, rvalid, rdata, rlast, rresp, rid
  );
endinterface

// File: rtl/mem_read_dma.sv
// Read-DMA engine: on Go, fetches Length bytes from memory with INCR bursts
// (max 16 beats, never crossing a 4KB page, one burst outstanding) and
// streams the 64-bit words in order through a 2-entry output buffer.
module mem_read_dma #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 4,
  parameter int ID_WIDTH   = 6,
  parameter int READ_ID    = 0
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  Go,
  input  logic [29:0]           Src_addr,
  input  logic [31:0]           Length,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Err,
  mem_read_dma_if.master        m_memory,
  output logic                  Out_valid,
  input  logic                  Out_ready,
  output logic [DATA_WIDTH-1:0] Out_data,
  output logic                  Out_last
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, FINISH} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [28:0]           remaining;
  logic [28:0]           total_beats;
  logic [9:0]            to_bound;
  logic [4:0]            burst_n;
  logic                  go_ok;
  logic                  push;
  logic                  pop;
  logic                  final_beat;
  logic                  err_q;

  logic [DATA_WIDTH-1:0] fifo_data [2];
  logic [1:0]            fifo_last;
  logic                  wr_idx;
  logic                  rd_idx;
  logic [1:0]            count;

  logic                  arvalid;
  logic                  rready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [LEN_WIDTH-1:0]  arlen;
  logic                  unused_rid;

  // The trailing partial word is fetched and delivered whole.
  assign total_beats = Length[31:3] + {28'd0, |Length[2:0]};
  assign to_bound    = 10'd512 - {1'b0, ptr[11:3]};
  assign go_ok       = (state == IDLE) && Go;
  assign push        = m_memory.rvalid && rready;
  assign pop         = Out_valid && Out_ready;
  assign final_beat  = m_memory.rlast && (remaining == 29'd0);
  assign unused_rid  = ^m_memory.rid;

  // Burst size: min(16, remaining beats, beats left in the 4KB page).
  always_comb begin
    burst_n = 5'd16;
    if (remaining < 29'd16) burst_n = remaining[4:0];
    if (to_bound < {5'd0, burst_n}) burst_n = to_bound[4:0];
  end

  // State register.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; only one burst is ever outstanding.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (Go) state_nxt = (Length == 32'd0) ? FINISH : ADDR;
      ADDR:   if (m_memory.arready) state_nxt = DATA;
      DATA:   if (push && m_memory.rlast)
                state_nxt = (remaining == 29'd0) ? FINISH : ADDR;
      FINISH: if (count == 2'd0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State-decoded outputs; AR fields derive from registers held through ADDR.
  always_comb begin
    arvalid = 1'b0;
    araddr  = '0;
    arlen   = '0;
    rready  = 1'b0;
    Busy    = (state != IDLE);
    Done    = 1'b0;
    case (state)
      ADDR: begin
        arvalid = 1'b1;
        araddr  = ptr;
        arlen   = LEN_WIDTH'(burst_n - 5'd1);
      end
      DATA:   rready = (count != 2'd2);
      FINISH: Done   = (count == 2'd0);
      default: ;
    endcase
  end

  assign m_memory.arvalid = arvalid;
  assign m_memory.araddr  = araddr;
  assign m_memory.arlen   = arlen;
  assign m_memory.arid    = ID_WIDTH'(READ_ID);
  assign m_memory.arsize  = 3'b011;
  assign m_memory.arburst = 2'b01;
  assign m_memory.arlock  = 2'b00;
  assign m_memory.arcache = 4'b0011;
  assign m_memory.arprot  = 3'b000;
  assign m_memory.arqos   = 4'b0000;
  assign m_memory.rready  = rready;

  // Transfer pointer and remaining-beat count: loaded on Go, advanced per AR.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      ptr       <= '0;
      remaining <= '0;
    end else if (go_ok) begin
      ptr       <= ADDR_WIDTH'({Src_addr, 2'b00});
      remaining <= total_beats;
    end else if (state == ADDR && m_memory.arready) begin
      ptr       <= ptr + ADDR_WIDTH'({burst_n, 3'b000});
      remaining <= remaining - {24'd0, burst_n};
    end
  end

  // Sticky error flag, cleared by an accepted Go.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)                                   err_q <= 1'b0;
    else if (go_ok)                               err_q <= 1'b0;
    else if (push && m_memory.rresp != 2'b00)     err_q <= 1'b1;
  end

  assign Err = err_q;

  // Output buffer control: indices, occupancy and last-word tags.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      wr_idx    <= 1'b0;
      rd_idx    <= 1'b0;
      count     <= 2'd0;
      fifo_last <= 2'b00;
    end else begin
      if (push) begin
        wr_idx            <= ~wr_idx;
        fifo_last[wr_idx] <= final_beat;
      end
      if (pop) rd_idx <= ~rd_idx;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Output buffer payload; needs no reset since occupancy gates visibility.
  always_ff @(posedge Clk) begin
    if (push) fifo_data[wr_idx] <= m_memory.rdata;
  end

  assign Out_valid = (count != 2'd0);
  assign Out_data  = fifo_data[rd_idx];
  assign Out_last  = Out_valid && fifo_last[rd_idx];

endmodule

// File: tb/tb_mem_read_dma.sv
// Bench for mem_read_dma: table of transfers with expected AR bursts and
// word counts, an AXI3 read-slave model returning address-derived data, and
// a stream consumer with programmable stall.
module tb_mem_read_dma;

  logic        Clk;
  logic        Rst_n;
  logic        Go;
  logic [29:0] Src_addr;
  logic [31:0] Length;
  logic        Busy, Done, Err;
  logic        Out_valid, Out_ready, Out_last;
  logic [63:0] Out_data;

  mem_read_dma_if mem_if ();

  mem_read_dma dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .Go        (Go),
    .Src_addr  (Src_addr),
    .Length    (Length),
    .Busy      (Busy),
    .Done      (Done),
    .Err       (Err),
    .m_memory  (mem_if),
    .Out_valid (Out_valid),
    .Out_ready (Out_ready),
    .Out_data  (Out_data),
    .Out_last  (Out_last)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [31:0] src;
    logic [31:0] len;
    int          ar_delay;
    int          stall_at;
    int          stall_len;
    int          err_beat;
    logic        go_busy;
    logic        exp_err;
    int          n_ar;
    logic [31:0] ar0_addr;
    logic [3:0]  ar0_len;
    logic [31:0] ar1_addr;
    logic [3:0]  ar1_len;
    int          n_words;
  } vec_t;

  vec_t vecs [8];
  int   nv = 0;

  int n_vec = 0;
  int n_fail = 0;
  logic prev_err = 1'b0;

  // shared with slave / consumer processes
  int          ar_delay = 0;
  int          err_beat = -1;
  int          beat_idx = 0;
  int          stall_at = 0;
  int          stall_left = 0;
  int          ar_n = 0;
  int          rx_n = 0;
  logic [31:0] ar_addr_log [4];
  logic [3:0]  ar_len_log [4];
  logic [63:0] rx_data [64];
  logic        rx_last [64];

  function automatic logic [63:0] mem_word(input logic [31:0] a);
    return {~a, a};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [31:0] src, input logic [31:0] len,
                         input int dly, input int s_at, input int s_len,
                         input int eb, input logic gb, input logic ee,
                         input int nar, input logic [31:0] a0, input logic [3:0] l0,
                         input logic [31:0] a1, input logic [3:0] l1, input int nw);
    vec_t v;
    v.src = src; v.len = len; v.ar_delay = dly; v.stall_at = s_at;
    v.stall_len = s_len; v.err_beat = eb; v.go_busy = gb; v.exp_err = ee;
    v.n_ar = nar; v.ar0_addr = a0; v.ar0_len = l0; v.ar1_addr = a1;
    v.ar1_len = l1; v.n_words = nw;
    vecs[nv] = v;
    nv++;
  endtask

  // AXI3 read slave: one burst at a time, optional AR stall, optional SLVERR.
  initial begin : slave
    logic [31:0] a0;
    logic [3:0]  l0;
    logic        ok, hs;
    mem_if.arready = 1'b0;
    mem_if.rvalid  = 1'b0;
    mem_if.rdata   = '0;
    mem_if.rlast   = 1'b0;
    mem_if.rresp   = 2'b00;
    mem_if.rid     = '0;
    forever begin
      @(posedge Clk); #1;
      if (Rst_n && mem_if.arvalid) begin
        a0 = mem_if.araddr;
        l0 = mem_if.arlen;
        ok = 1'b1;
        check("ar_const", {mem_if.arsize, mem_if.arburst, mem_if.arlock, mem_if.arcache,
                           mem_if.arprot, mem_if.arqos, mem_if.arid},
              {3'b011, 2'b01, 2'b00, 4'b0011, 3'b000, 4'b0000, 6'd0});
        for (int d = 0; d < ar_delay; d++) begin
          @(posedge Clk); #1;
          if (!Rst_n) begin ok = 1'b0; break; end
          check("ar_stable", {mem_if.arvalid, mem_if.araddr, mem_if.arlen}, {1'b1, a0, l0});
        end
        if (ok) begin
          mem_if.arready = 1'b1;
          @(posedge Clk); #1;
          mem_if.arready = 1'b0;
          if (ar_n < 4) begin
            ar_addr_log[ar_n] = a0;
            ar_len_log[ar_n]  = l0;
          end
          ar_n++;
          for (int b = 0; b <= int'(l0) && ok; b++) begin
            mem_if.rvalid = 1'b1;
            mem_if.rdata  = mem_word(a0 + 32'(b * 8));
            mem_if.rlast  = (b == int'(l0));
            mem_if.rresp  = (beat_idx == err_beat) ? 2'b10 : 2'b00;
            hs = 1'b0;
            while (!hs && ok) begin
              hs = mem_if.rready;
              @(posedge Clk); #1;
              if (!Rst_n) ok = 1'b0;
            end
            beat_idx++;
          end
          mem_if.rvalid = 1'b0;
          mem_if.rlast  = 1'b0;
          mem_if.rresp  = 2'b00;
        end
      end
    end
  end

  // Stream consumer: records accepted words, stalls when asked.
  initial begin : consumer
    Out_ready = 1'b1;
    forever begin
      @(posedge Clk); #1;
      if (stall_left > 0 && rx_n >= stall_at) begin
        Out_ready = 1'b0;
        stall_left--;
        if (stall_left == 4) begin
          check("bp_rready_low", mem_if.rready, 1'b0);
          check("bp_out_valid", Out_valid, 1'b1);
        end
      end else begin
        Out_ready = 1'b1;
      end
      if (Out_valid && Out_ready && rx_n < 64) begin
        rx_data[rx_n] = Out_data;
        rx_last[rx_n] = Out_last;
        rx_n++;
      end
    end
  end

  task automatic run_vec(input int i);
    vec_t v;
    int   cyc;
    v = vecs[i];
    rx_n = 0; ar_n = 0; beat_idx = 0;
    err_beat = v.err_beat; ar_delay = v.ar_delay;
    stall_at = v.stall_at; stall_left = v.stall_len;
    check("err_before_go", Err, prev_err);
    Go = 1'b1; Src_addr = v.src[31:2]; Length = v.len;
    @(posedge Clk); #1;
    Go = 1'b0;
    check("busy_after_go", Busy, 1'b1);
    check("err_cleared", Err, 1'b0);
    check("arvalid_after_go", mem_if.arvalid, v.len != 0);
    if (v.len == 0) check("done_len0", Done, 1'b1);
    if (v.go_busy) begin
      repeat (3) begin @(posedge Clk); #1; end
      Go = 1'b1; Src_addr = 30'h1C00; Length = 32'd8;
      @(posedge Clk); #1;
      Go = 1'b0;
      check("busy_during_go", Busy, 1'b1);
    end
    cyc = 0;
    while (!Done && cyc < 3000) begin
      @(posedge Clk); #1;
      cyc++;
    end
    check("done_seen", Done, 1'b1);
    check("ar_count", ar_n, v.n_ar);
    if (v.n_ar >= 1) check("ar0", {ar_addr_log[0], ar_len_log[0]}, {v.ar0_addr, v.ar0_len});
    if (v.n_ar >= 2) check("ar1", {ar_addr_log[1], ar_len_log[1]}, {v.ar1_addr, v.ar1_len});
    check("word_count", rx_n, v.n_words);
    for (int k = 0; k < rx_n && k < 64; k++) begin
      check("word_data", rx_data[k], mem_word(v.src + 32'(k * 8)));
      check("word_last", rx_last[k], k == v.n_words - 1);
    end
    check("err_final", Err, v.exp_err);
    @(posedge Clk); #1;
    check("busy_after_done", Busy, 1'b0);
    check("done_one_cycle", Done, 1'b0);
    prev_err = v.exp_err;
  endtask

  initial begin : main
    int cyc;
    //      src         len  dly stl_at stl_len errb gb ee nar ar0          l0  ar1          l1  nw
    add_vec(32'h1000,  64,   0,  0,     0,      -1,  0, 0, 1, 32'h1000,  7, 32'h0,     0,  8);
    add_vec(32'h1000,  200,  0,  0,     0,      -1,  1, 0, 2, 32'h1000, 15, 32'h1080,  8, 25);
    add_vec(32'h0FF0,  64,   0,  0,     0,      -1,  0, 0, 2, 32'h0FF0,  1, 32'h1000,  5,  8);
    add_vec(32'h2000,  12,   0,  0,     0,      -1,  0, 0, 1, 32'h2000,  1, 32'h0,     0,  2);
    add_vec(32'h3000,  0,    0,  0,     0,      -1,  0, 0, 0, 32'h0,     0, 32'h0,     0,  0);
    add_vec(32'h4000,  64,   0,  0,     0,       2,  0, 1, 1, 32'h4000,  7, 32'h0,     0,  8);
    add_vec(32'h5000,  128,  5,  4,     10,     -1,  0, 0, 1, 32'h5000, 15, 32'h0,     0, 16);

    Rst_n = 1'b0; Go = 1'b0; Src_addr = '0; Length = '0;
    repeat (3) @(posedge Clk);
    #1;
    check("rst_busy", Busy, 1'b0);
    check("rst_done", Done, 1'b0);
    check("rst_err", Err, 1'b0);
    check("rst_ar", {mem_if.arvalid, mem_if.araddr, mem_if.arlen, mem_if.arid}, '0);
    check("rst_out", {Out_valid, Out_last, mem_if.rready}, '0);
    Rst_n = 1'b1;
    repeat (2) begin @(posedge Clk); #1; end

    for (int i = 0; i < nv; i++) run_vec(i);

    // Reset in the middle of a data phase.
    rx_n = 0; ar_n = 0; beat_idx = 0; err_beat = -1; ar_delay = 0; stall_left = 0;
    Go = 1'b1; Src_addr = 30'h1800; Length = 32'd128;
    @(posedge Clk); #1;
    Go = 1'b0;
    cyc = 0;
    while (rx_n < 3 && cyc < 200) begin
      @(posedge Clk); #1;
      cyc++;
    end
    check("midrst_progress", rx_n >= 3, 1'b1);
    Rst_n = 1'b0;
    #1;
    check("midrst_busy_done_err", {Busy, Done, Err}, 3'b000);
    check("midrst_ar", {mem_if.arvalid, mem_if.araddr, mem_if.arlen}, '0);
    check("midrst_out", {Out_valid, Out_last, mem_if.rready}, 3'b000);
    repeat (3) begin @(posedge Clk); #1; end
    Rst_n = 1'b1;
    repeat (3) begin @(posedge Clk); #1; end
    prev_err = 1'b0;
    run_vec(0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
